// File: rtl/anton_neopixel_stream_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// anton_neopixel_stream_sequencer_pkg
// Shared constants for the NeoPixel stream sequencer: the 2-bit state
// encoding, default buffer/latch sizes and the per-pixel data bit counts.
// ---------------------------------------------------------------------------
package anton_neopixel_stream_sequencer_pkg;

    typedef enum logic [1:0] {
        ENUM_STATE_IDLE     = 2'd0,
        ENUM_STATE_TRANSMIT = 2'd1,
        ENUM_STATE_LATCH    = 2'd2
    } state_e;

    localparam int BUFFER_END_DEFAULT  = 255;
    // 350 cycles of a 7 MHz clock is a 50 us latch interval.
    localparam int RESET_DELAY_DEFAULT = 349;

    localparam int PIXEL_BITS_RGB  = 24;
    localparam int PIXEL_BITS_RGBW = 32;

endpackage

// File: rtl/anton_neopixel_stream_sequencer_latch_timer.sv
// ---------------------------------------------------------------------------
// anton_neopixel_latch_timer
// Delay counter for the latch interval. Counts while en_i is high, clears
// synchronously on clr_i, and raises terminal_o (combinational) on the cycle
// the count equals DELAY; the counter returns to 0 on that edge.
//   clk, rst    : clock, asynchronous active-high reset
//   en_i        : count enable
//   clr_i       : synchronous clear (priority over en_i)
//   terminal_o  : count == DELAY while enabled
// ---------------------------------------------------------------------------
module anton_neopixel_latch_timer #(
    parameter int DELAY = 9,
    parameter int WIDTH = $clog2(DELAY + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic terminal_o
);

    logic [WIDTH-1:0] count_q;

    assign terminal_o = en_i && (count_q == WIDTH'(DELAY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= terminal_o ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/anton_neopixel_stream_sequencer.sv
// ---------------------------------------------------------------------------
// anton_neopixel_stream_sequencer
// Walks sub-bit pattern steps, pixel bits and pixel byte indices through the
// frame buffer, then holds the latch interval. IDLE -> TRANSMIT -> LATCH,
// with one-shot or loop frame mode, RGB/RGBW pixels and word-aligned indices.
//   clk7mhz, rst          : clock, asynchronous active-high reset
//   reg_ctrl_*            : control bits from the register block
//   reg_max               : software end index (used when limit is set)
//   bit_pattern_index     : sub-bit step within the current data bit
//   pixel_bit_index       : data bit within the current pixel
//   pixel_index           : byte index of the current pixel
//   pixel_index_max       : effective end index (combinational)
//   state                 : 0 IDLE, 1 TRANSMIT, 2 LATCH
//   stream_output/reset   : datapath enables for TRANSMIT / LATCH
//   stream_*_of           : bit, pixel (frame) and latch overflow strobes
//   frame_done            : pulse on the last latch cycle
//   frame_count           : completed frames, wraps
// Control handshake: there is no valid/ready pairing here; reg_ctrl_run acts
// as a level enable and every counter advances only on edges where run is 1
// and init is 0.
// ---------------------------------------------------------------------------
module anton_neopixel_stream_sequencer
    import anton_neopixel_stream_sequencer_pkg::*;
#(
    parameter int BUFFER_END   = BUFFER_END_DEFAULT,
    parameter int RESET_DELAY  = RESET_DELAY_DEFAULT,
    parameter int PATTERN_BITS = 3,
    parameter int BUFFER_BITS  = $clog2(BUFFER_END + 1),
    parameter int DELAY_BITS   = $clog2(RESET_DELAY + 1)
) (
    input  logic                    clk7mhz,
    input  logic                    rst,
    input  logic                    reg_ctrl_init,
    input  logic                    reg_ctrl_run,
    input  logic                    reg_ctrl_loop,
    input  logic                    reg_ctrl_limit,
    input  logic                    reg_ctrl_32bit,
    input  logic                    reg_ctrl_rgbw,
    input  logic [12:0]             reg_max,
    output logic [PATTERN_BITS-1:0] bit_pattern_index,
    output logic [4:0]              pixel_bit_index,
    output logic [BUFFER_BITS-1:0]  pixel_index,
    output logic [BUFFER_BITS-1:0]  pixel_index_max,
    output logic [1:0]              state,
    output logic                    stream_output,
    output logic                    stream_reset,
    output logic                    stream_bit_of,
    output logic                    stream_pixel_of,
    output logic                    stream_sync_of,
    output logic                    frame_done,
    output logic [15:0]             frame_count
);

    localparam logic [BUFFER_BITS-1:0] END_IDX = BUFFER_BITS'(BUFFER_END);

    state_e                  state_q;
    logic [PATTERN_BITS-1:0] pattern_q;
    logic [4:0]              bit_q;
    logic [BUFFER_BITS-1:0]  pix_q;
    logic [15:0]             frame_count_q;

    logic [BUFFER_BITS-1:0]  max_trunc;
    logic [BUFFER_BITS-1:0]  equiv_idx;
    logic [BUFFER_BITS-1:0]  pix_step;
    logic                    pattern_of;
    logic                    bit_wrap;
    logic                    last_pixel;
    logic                    unused_reg_max_bits;

    // Only the low BUFFER_BITS of reg_max address the buffer.
    assign max_trunc           = reg_max[BUFFER_BITS-1:0];
    assign unused_reg_max_bits = ^reg_max[12:BUFFER_BITS];
    assign pixel_index_max     = !reg_ctrl_limit     ? END_IDX :
                                 (max_trunc > END_IDX) ? END_IDX : max_trunc;

    assign stream_output = reg_ctrl_run && !reg_ctrl_init && (state_q == ENUM_STATE_TRANSMIT);
    assign stream_reset  = reg_ctrl_run && !reg_ctrl_init && (state_q == ENUM_STATE_LATCH);

    assign pattern_of = stream_output && (&pattern_q);
    // Wrap at 31 is always honoured so a bit index above 23 still terminates
    // if rgbw is dropped mid-pixel.
    assign bit_wrap   = (bit_q == 5'd31) || (!reg_ctrl_rgbw && (bit_q == 5'd23));
    assign stream_bit_of = pattern_of && bit_wrap;

    // In word mode the last byte of the word is compared against the end index.
    assign equiv_idx  = reg_ctrl_32bit ? {pix_q[BUFFER_BITS-1:2], 2'b11} : pix_q;
    assign last_pixel = (equiv_idx == pixel_index_max);
    assign stream_pixel_of = stream_bit_of && last_pixel;
    assign pix_step   = reg_ctrl_32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1);

    anton_neopixel_latch_timer #(
        .DELAY (RESET_DELAY),
        .WIDTH (DELAY_BITS)
    ) u_latch_timer (
        .clk        (clk7mhz),
        .rst        (rst),
        .en_i       (stream_reset),
        .clr_i      (reg_ctrl_init),
        .terminal_o (stream_sync_of)
    );

    assign frame_done = stream_sync_of;

    always_ff @(posedge clk7mhz or posedge rst) begin
        if (rst) begin
            state_q   <= ENUM_STATE_IDLE;
            pattern_q <= '0;
            bit_q     <= '0;
            pix_q     <= '0;
        end else if (reg_ctrl_init) begin
            state_q   <= ENUM_STATE_IDLE;
            pattern_q <= '0;
            bit_q     <= '0;
            pix_q     <= '0;
        end else if (reg_ctrl_run) begin
            case (state_q)
                ENUM_STATE_IDLE: begin
                    state_q <= ENUM_STATE_TRANSMIT;
                end
                ENUM_STATE_TRANSMIT: begin
                    pattern_q <= pattern_q + 1'b1;
                    if (pattern_of) begin
                        bit_q <= bit_wrap ? 5'd0 : bit_q + 5'd1;
                    end
                    if (stream_bit_of) begin
                        if (last_pixel) begin
                            pix_q   <= '0;
                            state_q <= ENUM_STATE_LATCH;
                        end else begin
                            pix_q <= pix_q + pix_step;
                        end
                    end
                end
                ENUM_STATE_LATCH: begin
                    if (stream_sync_of) begin
                        state_q <= reg_ctrl_loop ? ENUM_STATE_TRANSMIT : ENUM_STATE_IDLE;
                    end
                end
                default: begin
                    state_q <= ENUM_STATE_IDLE;
                end
            endcase
        end
    end

    // Not touched by init: frames completed survive a soft clear.
    always_ff @(posedge clk7mhz or posedge rst) begin
        if (rst) begin
            frame_count_q <= '0;
        end else if (stream_sync_of) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign bit_pattern_index = pattern_q;
    assign pixel_bit_index   = bit_q;
    assign pixel_index       = pix_q;
    assign state             = state_q;
    assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_anton_neopixel_stream_sequencer.sv
// Directed bench for the NeoPixel stream sequencer. A position-based model
// (linear cycle count within a frame) predicts every output each cycle.
module tb_anton_neopixel_stream_sequencer;
  localparam int BE = 15;
  localparam int RD = 9;
  localparam int PB = 3;
  localparam int BB = 4;
  localparam int STEPS = 1 << PB;

  // clock / reset / inputs
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b0, run = 1'b0, loop_m = 1'b0, limit = 1'b0, b32 = 1'b0, rgbw = 1'b0;
  logic [12:0] reg_max = '0;

  logic [PB-1:0] bit_pattern_index;
  logic [4:0]    pixel_bit_index;
  logic [BB-1:0] pixel_index, pixel_index_max;
  logic [1:0]    state;
  logic stream_output, stream_reset, stream_bit_of, stream_pixel_of, stream_sync_of, frame_done;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  anton_neopixel_stream_sequencer #(
    .BUFFER_END(BE), .RESET_DELAY(RD), .PATTERN_BITS(PB)
  ) dut (
    .clk7mhz(clk), .rst(rst), .reg_ctrl_init(init), .reg_ctrl_run(run),
    .reg_ctrl_loop(loop_m), .reg_ctrl_limit(limit), .reg_ctrl_32bit(b32),
    .reg_ctrl_rgbw(rgbw), .reg_max(reg_max),
    .bit_pattern_index(bit_pattern_index), .pixel_bit_index(pixel_bit_index),
    .pixel_index(pixel_index), .pixel_index_max(pixel_index_max), .state(state),
    .stream_output(stream_output), .stream_reset(stream_reset),
    .stream_bit_of(stream_bit_of), .stream_pixel_of(stream_pixel_of),
    .stream_sync_of(stream_sync_of), .frame_done(frame_done), .frame_count(frame_count)
  );

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: mode 0 idle, 1 transmit, 2 latch; m_t = transmit cycle within frame
  int m_mode = 0, m_t = 0, m_l = 0, m_frames = 0;

  function automatic int eff_max();
    int r;
    if (!limit) return BE;
    r = int'(reg_max) % (1 << BB);
    return (r > BE) ? BE : r;
  endfunction
  function automatic int bpp();
    return rgbw ? 32 : 24;
  endfunction
  function automatic int npix();
    return b32 ? (eff_max() / 4 + 1) : (eff_max() + 1);
  endfunction
  function automatic int total_tx();
    return npix() * bpp() * STEPS;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_t = 0; m_l = 0; m_frames = 0;
    end else if (init) begin
      m_mode = 0; m_t = 0; m_l = 0;
    end else if (run) begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          m_t++;
          if (m_t == total_tx()) begin m_t = 0; m_mode = 2; end
        end
        default: begin
          if (m_l == RD) begin
            m_l = 0; m_frames++; m_mode = loop_m ? 1 : 0;
          end else m_l++;
        end
      endcase
    end
  end

  // compare process: every negedge
  always @(negedge clk) begin
    int e_pat, e_bit, e_pix, e_so, e_rs, e_bof, e_pof, e_sync;
    e_pat = 0; e_bit = 0; e_pix = 0;
    if (m_mode == 1) begin
      e_pat = m_t % STEPS;
      e_bit = (m_t / STEPS) % bpp();
      e_pix = ((m_t / (STEPS * bpp())) * (b32 ? 4 : 1)) % (1 << BB);
    end
    e_so   = (run && !init && m_mode == 1) ? 1 : 0;
    e_rs   = (run && !init && m_mode == 2) ? 1 : 0;
    e_bof  = (e_so != 0 && (m_t % (STEPS * bpp())) == STEPS * bpp() - 1) ? 1 : 0;
    e_pof  = (e_so != 0 && m_t == total_tx() - 1) ? 1 : 0;
    e_sync = (e_rs != 0 && m_l == RD) ? 1 : 0;
    check("state", int'(state), m_mode);
    check("pattern", int'(bit_pattern_index), e_pat);
    check("pixel_bit", int'(pixel_bit_index), e_bit);
    check("pixel_index", int'(pixel_index), e_pix);
    check("pixel_index_max", int'(pixel_index_max), eff_max());
    check("stream_output", int'(stream_output), e_so);
    check("stream_reset", int'(stream_reset), e_rs);
    check("stream_bit_of", int'(stream_bit_of), e_bof);
    check("stream_pixel_of", int'(stream_pixel_of), e_pof);
    check("stream_sync_of", int'(stream_sync_of), e_sync);
    check("frame_done", int'(frame_done), e_sync);
    check("frame_count", int'(frame_count), m_frames % 65536);
  end

  // driver helpers
  task automatic wait_state(input int s, input int budget, input string name);
    int i;
    for (i = 0; i < budget && int'(state) != s; i++) @(negedge clk);
    if (int'(state) != s) check({name, "_timeout"}, int'(state), s);
  endtask

  initial begin : timeout_guard
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int txc, latc, dones, first_pof, seen4;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_frame_count", int'(frame_count), 0);
    check("rst_pattern", int'(bit_pattern_index), 0);
    #1 rst = 1'b0;
    limit = 1'b1; reg_max = 13'h0123;  // truncates to 3 -> 4 pixels
    @(negedge clk);
    check("max_trunc", int'(pixel_index_max), 3);

    // test 1: one-shot RGB frame
    #1 run = 1'b1;
    txc = 0; latc = 0; dones = 0;
    @(negedge clk);
    check("start_state", int'(state), 1);
    check("start_output", int'(stream_output), 1);
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) @(negedge clk);
      if (stream_output) txc++;
      if (stream_reset) latc++;
      if (frame_done) dones++;
      if (int'(state) == 0) break;
    end
    check("t1_tx_cycles", txc, 768);
    check("t1_latch_cycles", latc, 10);
    check("t1_done_pulses", dones, 1);
    check("t1_frame_count", int'(frame_count), 1);
    check("t1_state_idle", int'(state), 0);
    #1 run = 1'b0;

    // freeze at pattern 5, bit 7
    @(negedge clk);
    #1 run = 1'b1;
    begin
      int i;
      for (i = 0; i < 2000 && !(bit_pattern_index == 3'd5 && pixel_bit_index == 5'd7); i++)
        @(negedge clk);
      if (!(bit_pattern_index == 3'd5 && pixel_bit_index == 5'd7))
        check("freeze_find_timeout", 0, 1);
    end
    #1 run = 1'b0;
    repeat (20) @(negedge clk);
    check("freeze_pattern", int'(bit_pattern_index), 5);
    check("freeze_bit", int'(pixel_bit_index), 7);
    check("freeze_state", int'(state), 1);
    #1 run = 1'b1;
    @(negedge clk);
    check("resume_pattern", int'(bit_pattern_index), 6);
    wait_state(0, 2000, "freeze_end");
    #1 run = 1'b0;
    check("freeze_frames", int'(frame_count), 2);

    // init collision with the latch terminal cycle
    @(negedge clk);
    #1 run = 1'b1;
    begin
      int i;
      for (i = 0; i < 2000; i++) begin
        @(posedge clk); #1;
        if (m_mode == 2 && m_l == RD) break;
      end
      if (!(m_mode == 2 && m_l == RD)) check("coll_find_timeout", 0, 1);
    end
    init = 1'b1;
    @(negedge clk);
    check("coll_done", int'(frame_done), 0);
    check("coll_sync", int'(stream_sync_of), 0);
    @(posedge clk); #1;
    init = 1'b0; run = 1'b0;
    @(negedge clk);
    check("coll_state", int'(state), 0);
    check("coll_frame_count", int'(frame_count), 2);

    // async reset during LATCH
    #1 run = 1'b1;
    wait_state(2, 2000, "rst_latch");
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_frame_count", int'(frame_count), 0);
    check("arst_pattern", int'(bit_pattern_index), 0);
    check("arst_stream_reset", int'(stream_reset), 0);
    @(negedge clk);
    #1 rst = 1'b0; run = 1'b0;

    // loop mode, RGBW + 32bit, reg_max 7 -> indices 0 and 4
    b32 = 1'b1; rgbw = 1'b1; reg_max = 13'd7; loop_m = 1'b1;
    @(negedge clk);
    check("loop_max", int'(pixel_index_max), 7);
    #1 run = 1'b1;
    txc = 0; dones = 0; first_pof = 1; seen4 = 0;
    for (int i = 0; i < 5000 && dones < 3; i++) begin
      @(negedge clk);
      if (stream_output && first_pof != 0) txc++;
      if (seen4 == 0 && int'(pixel_index) == 4) begin
        check("loop_pix4_cycle", txc, 257);
        seen4 = 1;
      end
      if (stream_pixel_of && first_pof != 0) begin
        check("loop_pof_cycle", txc, 512);
        first_pof = 0;
      end
      if (frame_done) begin
        dones++;
        @(negedge clk);
        check("loop_no_gap_output", int'(stream_output), 1);
        check("loop_no_gap_pattern", int'(bit_pattern_index), 0);
      end
    end
    check("loop_frame_count", int'(frame_count), 3);
    #1 init = 1'b1;
    @(negedge clk);
    #1 init = 1'b0; run = 1'b0; loop_m = 1'b0;
    repeat (3) @(negedge clk);
    check("final_state", int'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
